// File: rtl/mapper_004.sv
// mapper_004: MMC3-class bank-switching mapper. Eight bank registers, selectable PRG/CHR
// layouts, software mirroring, PRG-RAM protect and a scanline IRQ counter clocked by
// filtered PPU A12 rises. Everything runs on clk_cpu; ppu_addr is sampled synchronously.
module mapper_004 #(
  parameter int unsigned PRG_ROM_DEPTH = 17,
  parameter int unsigned CHR_ROM_DEPTH = 15,
  parameter int unsigned PRG_RAM_DEPTH = 13,
  parameter int unsigned A12_FILTER    = 3,
  parameter int unsigned IRQ_REV       = 1
) (
  input  logic                     clk_cpu,
  input  logic                     rst_n,
  input  logic [14:0]              cpu_addr,
  input  logic [7:0]               cpu_data_i,
  input  logic                     cpu_rw,
  input  logic                     romsel,
  input  logic [13:0]              ppu_addr,
  input  logic                     mirrorv,
  input  logic                     chr_ram,
  input  logic                     prg_ram,
  input  logic [PRG_ROM_DEPTH-1:0] prg_mask,
  input  logic [CHR_ROM_DEPTH-1:0] chr_mask,
  input  logic [PRG_RAM_DEPTH-1:0] prgram_mask,
  output logic [PRG_ROM_DEPTH-1:0] prg_addr,
  output logic [CHR_ROM_DEPTH-1:0] chr_addr,
  output logic [PRG_RAM_DEPTH-1:0] prgram_addr,
  output logic                     prg_cs,
  output logic                     chr_cs,
  output logic                     prgram_cs,
  output logic [7:0]               mapper_reg_o,
  output logic                     ciram_ce,
  output logic                     ciram_a10,
  output logic                     irq
);

  localparam int unsigned LrW = (A12_FILTER > 0) ? $clog2(A12_FILTER + 1) : 1;
  localparam logic [LrW-1:0] LrMax = LrW'(A12_FILTER);

  // Bank registers R0..R7, R0 in the least significant byte.
  logic [7:0][7:0] bank_q, bank_d;
  logic [2:0]      target_q, target_d;
  logic            prg_mode_q, prg_mode_d;
  logic            chr_inv_q, chr_inv_d;
  logic            mirror_q, mirror_d;
  logic            ram_en_q, ram_en_d;
  logic            ram_wp_q, ram_wp_d;
  logic [7:0]      irq_latch_q, irq_latch_d;
  logic [7:0]      irq_cnt_q, irq_cnt_d;
  logic            reload_q, reload_d;
  logic            irq_en_q, irq_en_d;
  logic            irq_q, irq_d;
  logic [LrW-1:0]  lowrun_q, lowrun_d;
  logic            a12_prev_q, a12_prev_d;

  logic            wr;
  logic            a12_rise;
  logic [31:0]     prg_bank;
  logic            chr_a;
  logic [7:0]      chr_bank;

  // chr_ram has no effect on this mapper's address generation.
  logic unused_chr_ram;
  assign unused_chr_ram = chr_ram;

  assign wr       = !romsel && !cpu_rw;
  assign a12_rise = ppu_addr[12] && !a12_prev_q && (lowrun_q == LrMax);

  // Next-state: register writes take priority and swallow a coincident A12 edge.
  always_comb begin
    bank_d      = bank_q;
    target_d    = target_q;
    prg_mode_d  = prg_mode_q;
    chr_inv_d   = chr_inv_q;
    mirror_d    = mirror_q;
    ram_en_d    = ram_en_q;
    ram_wp_d    = ram_wp_q;
    irq_latch_d = irq_latch_q;
    irq_cnt_d   = irq_cnt_q;
    reload_d    = reload_q;
    irq_en_d    = irq_en_q;
    irq_d       = irq_q;
    lowrun_d    = lowrun_q;
    a12_prev_d  = ppu_addr[12];

    if (ppu_addr[12]) begin
      lowrun_d = '0;
    end else if (lowrun_q != LrMax) begin
      lowrun_d = lowrun_q + LrW'(1);
    end

    if (wr) begin
      unique case ({cpu_addr[14:13], cpu_addr[0]})
        3'b000: begin
          target_d   = cpu_data_i[2:0];
          prg_mode_d = cpu_data_i[6];
          chr_inv_d  = cpu_data_i[7];
        end
        3'b001: bank_d[target_q] = cpu_data_i;
        3'b010: mirror_d = cpu_data_i[0];
        3'b011: begin
          ram_en_d = cpu_data_i[7];
          ram_wp_d = cpu_data_i[6];
        end
        3'b100: irq_latch_d = cpu_data_i;
        3'b101: begin
          irq_cnt_d = 8'd0;
          reload_d  = 1'b1;
        end
        3'b110: begin
          irq_en_d = 1'b0;
          irq_d    = 1'b0;
        end
        3'b111: irq_en_d = 1'b1;
        default: ;
      endcase
    end else if (a12_rise) begin
      if (irq_cnt_q == 8'd0 || reload_q) begin
        irq_cnt_d = irq_latch_q;
        reload_d  = 1'b0;
      end else begin
        irq_cnt_d = irq_cnt_q - 8'd1;
      end
      // Old rule only fires when the counter actually transitioned to zero or was reloaded.
      if (irq_cnt_d == 8'd0 && irq_en_q &&
          (IRQ_REV != 0 || irq_cnt_q != 8'd0 || reload_q)) begin
        irq_d = 1'b1;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_cpu) begin
    if (!rst_n) begin
      bank_q      <= {8'd1, 8'd0, 8'd7, 8'd6, 8'd5, 8'd4, 8'd2, 8'd0};
      target_q    <= 3'd0;
      prg_mode_q  <= 1'b0;
      chr_inv_q   <= 1'b0;
      mirror_q    <= !mirrorv;
      ram_en_q    <= 1'b1;
      ram_wp_q    <= 1'b0;
      irq_latch_q <= 8'd0;
      irq_cnt_q   <= 8'd0;
      reload_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
      lowrun_q    <= LrMax;
      a12_prev_q  <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      target_q    <= target_d;
      prg_mode_q  <= prg_mode_d;
      chr_inv_q   <= chr_inv_d;
      mirror_q    <= mirror_d;
      ram_en_q    <= ram_en_d;
      ram_wp_q    <= ram_wp_d;
      irq_latch_q <= irq_latch_d;
      irq_cnt_q   <= irq_cnt_d;
      reload_q    <= reload_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
      lowrun_q    <= lowrun_d;
      a12_prev_q  <= a12_prev_d;
    end
  end

  // PRG bank select. All-ones (and all-ones minus one) become the last (second-last)
  // bank once masked, for any power-of-two ROM size.
  always_comb begin
    prg_bank = 32'hFFFF_FFFF;
    unique case (cpu_addr[14:13])
      2'b00:   prg_bank = prg_mode_q ? 32'hFFFF_FFFE : {24'd0, bank_q[6]};
      2'b01:   prg_bank = {24'd0, bank_q[7]};
      2'b10:   prg_bank = prg_mode_q ? {24'd0, bank_q[6]} : 32'hFFFF_FFFE;
      default: prg_bank = 32'hFFFF_FFFF;
    endcase
  end

  // CHR bank select: 2k pair region and 1k region swap halves with chr_inv.
  always_comb begin
    chr_a = ppu_addr[12] ^ chr_inv_q;
    if (!chr_a) begin
      chr_bank = {(ppu_addr[11] ? bank_q[1][7:1] : bank_q[0][7:1]), ppu_addr[10]};
    end else begin
      chr_bank = bank_q[3'd2 + {1'b0, ppu_addr[11:10]}];
    end
  end

  // Memory addresses, selects and nametable control.
  always_comb begin
    prg_addr     = PRG_ROM_DEPTH'({prg_bank, cpu_addr[12:0]}) & prg_mask;
    prg_cs       = !romsel;
    prgram_cs    = romsel && (cpu_addr[14:13] == 2'b11) && prg_ram && ram_en_q &&
                   (cpu_rw || !ram_wp_q);
    prgram_addr  = PRG_RAM_DEPTH'(cpu_addr[12:0]) & prgram_mask;
    chr_addr     = CHR_ROM_DEPTH'({chr_bank, ppu_addr[9:0]}) & chr_mask;
    chr_cs       = !ppu_addr[13];
    ciram_ce     = ppu_addr[13];
    ciram_a10    = mirror_q ? ppu_addr[11] : ppu_addr[10];
    mapper_reg_o = 8'h00;
    irq          = irq_q;
  end

endmodule

// File: tb/tb_mapper_004.sv
// tb_mapper_004: directed scenarios plus randomized traffic, checked every cycle against a
// behavioural model of the mapper. Two DUTs run side by side, one per IRQ rule.
module tb_mapper_004;

  localparam int unsigned PrgW = 17;
  localparam int unsigned ChrW = 15;
  localparam int unsigned RamW = 13;
  localparam int unsigned Filt = 3;

  logic clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  logic            rst_n;
  logic [14:0]     cpu_addr;
  logic [7:0]      cpu_data_i;
  logic            cpu_rw;
  logic            romsel;
  logic [13:0]     ppu_addr;
  logic            mirrorv;
  logic            chr_ram;
  logic            prg_ram;
  logic [PrgW-1:0] prg_mask;
  logic [ChrW-1:0] chr_mask;
  logic [RamW-1:0] prgram_mask;

  logic [PrgW-1:0] prg_addr_w    [2];
  logic [ChrW-1:0] chr_addr_w    [2];
  logic [RamW-1:0] prgram_addr_w [2];
  logic            prg_cs_w      [2];
  logic            chr_cs_w      [2];
  logic            prgram_cs_w   [2];
  logic [7:0]      mapper_reg_w  [2];
  logic            ciram_ce_w    [2];
  logic            ciram_a10_w   [2];
  logic            irq_w         [2];

  // Index g is the DUT built with IRQ_REV = g.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mapper_004 #(
      .PRG_ROM_DEPTH(PrgW),
      .CHR_ROM_DEPTH(ChrW),
      .PRG_RAM_DEPTH(RamW),
      .A12_FILTER   (Filt),
      .IRQ_REV      (g)
    ) u_dut (
      .clk_cpu     (clk_cpu),
      .rst_n       (rst_n),
      .cpu_addr    (cpu_addr),
      .cpu_data_i  (cpu_data_i),
      .cpu_rw      (cpu_rw),
      .romsel      (romsel),
      .ppu_addr    (ppu_addr),
      .mirrorv     (mirrorv),
      .chr_ram     (chr_ram),
      .prg_ram     (prg_ram),
      .prg_mask    (prg_mask),
      .chr_mask    (chr_mask),
      .prgram_mask (prgram_mask),
      .prg_addr    (prg_addr_w[g]),
      .chr_addr    (chr_addr_w[g]),
      .prgram_addr (prgram_addr_w[g]),
      .prg_cs      (prg_cs_w[g]),
      .chr_cs      (chr_cs_w[g]),
      .prgram_cs   (prgram_cs_w[g]),
      .mapper_reg_o(mapper_reg_w[g]),
      .ciram_ce    (ciram_ce_w[g]),
      .ciram_a10   (ciram_a10_w[g]),
      .irq         (irq_w[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_r [8];
  logic [2:0] m_target;
  logic       m_prg_mode, m_chr_inv, m_mirror, m_ram_en, m_ram_wp, m_irq_en, m_reload;
  logic [7:0] m_latch, m_cnt;
  logic       m_irq  [2];
  logic       m_hist [Filt];  // most recent A12 samples, [0] newest
  bit         model_valid = 1'b0;

  always @(posedge clk_cpu) begin : model
    logic [7:0] r [8];
    logic [2:0] tgt;
    logic       pm, ci, mir, ren, rwp, ien, rld, old_rld, low_long, a12_edge, wr;
    logic [7:0] lat, cnt, old_cnt;
    logic       iq   [2];
    logic       hist [Filt];
    r = m_r; tgt = m_target; pm = m_prg_mode; ci = m_chr_inv; mir = m_mirror;
    ren = m_ram_en; rwp = m_ram_wp; ien = m_irq_en; rld = m_reload;
    lat = m_latch; cnt = m_cnt; iq = m_irq; hist = m_hist;
    if (!rst_n) begin
      r = '{8'd0, 8'd2, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0, 8'd1};
      tgt = 3'd0; pm = 1'b0; ci = 1'b0; mir = !mirrorv; ren = 1'b1; rwp = 1'b0;
      lat = 8'd0; cnt = 8'd0; rld = 1'b0; ien = 1'b0;
      iq[0] = 1'b0; iq[1] = 1'b0;
      for (int i = 0; i < Filt; i++) hist[i] = 1'b0;
    end else begin
      low_long = 1'b1;
      for (int i = 0; i < Filt; i++) if (hist[i]) low_long = 1'b0;
      a12_edge = ppu_addr[12] && low_long;
      wr = !romsel && !cpu_rw;
      if (wr) begin
        case ({cpu_addr[14:13], cpu_addr[0]})
          3'd0: begin tgt = cpu_data_i[2:0]; pm = cpu_data_i[6]; ci = cpu_data_i[7]; end
          3'd1: r[tgt] = cpu_data_i;
          3'd2: mir = cpu_data_i[0];
          3'd3: begin ren = cpu_data_i[7]; rwp = cpu_data_i[6]; end
          3'd4: lat = cpu_data_i;
          3'd5: begin cnt = 8'd0; rld = 1'b1; end
          3'd6: begin ien = 1'b0; iq[0] = 1'b0; iq[1] = 1'b0; end
          default: ien = 1'b1;
        endcase
      end else if (a12_edge) begin
        old_cnt = cnt;
        old_rld = rld;
        if (cnt == 0 || rld) begin cnt = lat; rld = 1'b0; end
        else cnt = cnt - 8'd1;
        if (cnt == 0 && ien) begin
          iq[1] = 1'b1;
          if (old_cnt != 0 || old_rld) iq[0] = 1'b1;
        end
      end
      for (int i = Filt - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = ppu_addr[12];
    end
    m_r <= r; m_target <= tgt; m_prg_mode <= pm; m_chr_inv <= ci; m_mirror <= mir;
    m_ram_en <= ren; m_ram_wp <= rwp; m_irq_en <= ien; m_reload <= rld;
    m_latch <= lat; m_cnt <= cnt; m_irq <= iq; m_hist <= hist;
    model_valid <= 1'b1;
  end

  // Compare all outputs of both DUTs against the model away from the active edge.
  always @(negedge clk_cpu) begin : compare
    logic [31:0] last, bank, e_prg, e_chr;
    logic [7:0]  cb;
    if (model_valid) begin
      last = 32'(prg_mask) >> 13;
      case (cpu_addr[14:13])
        2'd0:    bank = m_prg_mode ? last - 32'd1 : 32'(m_r[6]);
        2'd1:    bank = 32'(m_r[7]);
        2'd2:    bank = m_prg_mode ? 32'(m_r[6]) : last - 32'd1;
        default: bank = last;
      endcase
      e_prg = ((bank << 13) | 32'(cpu_addr[12:0])) & 32'(prg_mask);
      if ((ppu_addr[12] ^ m_chr_inv) == 1'b0)
        cb = (m_r[ppu_addr[11]] & 8'hFE) | {7'd0, ppu_addr[10]};
      else
        cb = m_r[2 + int'(ppu_addr[11:10])];
      e_chr = (32'(cb) * 32'd1024 + 32'(ppu_addr[9:0])) & 32'(chr_mask);
      for (int g = 0; g < 2; g++) begin
        check("prg_addr", 32'(prg_addr_w[g]), e_prg);
        check("prg_cs", 32'(prg_cs_w[g]), 32'(!romsel));
        check("prgram_cs", 32'(prgram_cs_w[g]),
              32'(romsel && cpu_addr[14:13] == 2'b11 && prg_ram && m_ram_en &&
                  (cpu_rw || !m_ram_wp)));
        check("prgram_addr", 32'(prgram_addr_w[g]),
              32'(cpu_addr[12:0]) & 32'(prgram_mask));
        check("chr_addr", 32'(chr_addr_w[g]), e_chr);
        check("chr_cs", 32'(chr_cs_w[g]), 32'(!ppu_addr[13]));
        check("ciram_ce", 32'(ciram_ce_w[g]), 32'(ppu_addr[13]));
        check("ciram_a10", 32'(ciram_a10_w[g]),
              32'(m_mirror ? ppu_addr[11] : ppu_addr[10]));
        check("mapper_reg", 32'(mapper_reg_w[g]), 32'd0);
        check(g ? "irq_rev1" : "irq_rev0", 32'(irq_w[g]), 32'(m_irq[g]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_cpu);
    #2;
  endtask

  task automatic cpu_write(input logic [14:0] a, input logic [7:0] d);
    romsel = 1'b0; cpu_rw = 1'b0; cpu_addr = a; cpu_data_i = d;
    tick();
    romsel = 1'b1; cpu_rw = 1'b1;
  endtask

  // Hold A12 low for `lows` samples, then high for one sample.
  task automatic a12_pulse(input int lows);
    ppu_addr = 14'h0000;
    repeat (lows) tick();
    ppu_addr = 14'h1000;
    tick();
    ppu_addr = 14'h0000;
  endtask

  task automatic check_irq(input string name, input logic e0, input logic e1);
    #1;
    check({name, "_rev0"}, 32'(irq_w[0]), 32'(e0));
    check({name, "_rev1"}, 32'(irq_w[1]), 32'(e1));
  endtask

  initial begin
    logic a12;
    int   run_left;
    rst_n = 1'b0; romsel = 1'b1; cpu_rw = 1'b1; cpu_addr = '0; cpu_data_i = '0;
    ppu_addr = '0; mirrorv = 1'b0; chr_ram = 1'b0; prg_ram = 1'b1;
    prg_mask = 17'h1FFFF; chr_mask = 15'h7FFF; prgram_mask = 13'h1FFF;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state: last bank at $E000, no IRQ.
    cpu_addr = 15'h7FFF; #1;
    check("rst_prg_addr", 32'(prg_addr_w[1]), 32'h1FFFF);
    check("rst_prg_cs", 32'(prg_cs_w[1]), 32'd0);
    check_irq("rst_irq", 1'b0, 1'b0);
    romsel = 1'b0; #1;
    check("sel_prg_cs", 32'(prg_cs_w[1]), 32'd1);
    romsel = 1'b1;
    tick();

    // PRG mode 1 with R6 = 5.
    cpu_write(15'h0000, 8'h46);
    cpu_write(15'h0001, 8'h05);
    romsel = 1'b0; cpu_addr = 15'h0123; #1;
    check("prg_mode1_8000", 32'(prg_addr_w[1]), 32'h1C123);
    cpu_addr = 15'h4123; #1;
    check("prg_mode1_c000", 32'(prg_addr_w[1]), 32'h0A123);
    romsel = 1'b1;
    tick();

    // CHR inversion with R0 = 2.
    cpu_write(15'h0000, 8'h80);
    cpu_write(15'h0001, 8'h02);
    ppu_addr = 14'h1400; #1;
    check("chr_inv_2k", 32'(chr_addr_w[1]), 32'h0C00);
    ppu_addr = 14'h0400; #1;
    check("chr_inv_1k", 32'(chr_addr_w[1]), 32'h1400);
    ppu_addr = 14'h0000;
    tick();

    // IRQ: latch 2, reload, enable; fires on the third filtered edge.
    cpu_write(15'h4000, 8'd2);
    cpu_write(15'h4001, 8'd0);
    cpu_write(15'h6001, 8'd0);
    a12_pulse(3); check_irq("irq_edge1", 1'b0, 1'b0);
    a12_pulse(3); check_irq("irq_edge2", 1'b0, 1'b0);
    a12_pulse(3); check_irq("irq_edge3", 1'b1, 1'b1);
    // Short low run must not count: the next fire needs three full edges.
    a12_pulse(2);
    cpu_write(15'h6000, 8'd0); check_irq("irq_ack", 1'b0, 1'b0);
    cpu_write(15'h6001, 8'd0);
    a12_pulse(3); check_irq("filt_edge1", 1'b0, 1'b0);
    a12_pulse(3); check_irq("filt_edge2", 1'b0, 1'b0);
    a12_pulse(3); check_irq("filt_edge3", 1'b1, 1'b1);

    // Latch 0: new rule fires every edge, old rule only after a reload.
    cpu_write(15'h4000, 8'd0);
    cpu_write(15'h4001, 8'd0);
    cpu_write(15'h6000, 8'd0);
    cpu_write(15'h6001, 8'd0);
    a12_pulse(3); check_irq("lat0_reload", 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      cpu_write(15'h6000, 8'd0);
      cpu_write(15'h6001, 8'd0);
      a12_pulse(3); check_irq("lat0_repeat", 1'b0, 1'b1);
    end

    // Mid-operation reset with horizontal mirroring and header vertical.
    cpu_write(15'h2000, 8'h01);
    mirrorv = 1'b1; ppu_addr = 14'h0800; #1;
    check("mirror_h", 32'(ciram_a10_w[1]), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_irq("mid_rst_irq", 1'b0, 1'b0);
    check("mid_rst_a10", 32'(ciram_a10_w[1]), 32'd0);

    // Randomized traffic.
    prg_mask    = PrgW'((32'd1 << (13 + $urandom_range(0, 4))) - 1);
    chr_mask    = ChrW'((32'd1 << (10 + $urandom_range(0, 5))) - 1);
    prgram_mask = RamW'((32'd1 << (11 + $urandom_range(0, 2))) - 1);
    a12 = 1'b0;
    run_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        prg_mask = 17'h1FFFF; chr_mask = 15'h7FFF; prgram_mask = 13'h1FFF;
      end
      rst_n = ($urandom_range(0, 299) != 0);
      if (!rst_n) mirrorv = 1'($urandom);
      if (run_left == 0) begin
        a12 = !a12;
        run_left = $urandom_range(1, 5);
      end
      run_left--;
      ppu_addr = 14'($urandom);
      ppu_addr[12] = a12;
      cpu_addr = 15'($urandom);
      cpu_data_i = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        romsel = 1'b0; cpu_rw = 1'b0;
        if ({cpu_addr[14:13], cpu_addr[0]} == 3'b100) cpu_data_i = 8'($urandom_range(0, 3));
      end else begin
        romsel = 1'($urandom);
        cpu_rw = romsel ? 1'($urandom) : 1'b1;
      end
      prg_ram = ($urandom_range(0, 7) != 0);
      chr_ram = 1'($urandom);
      tick();
    end

    romsel = 1'b1; cpu_rw = 1'b1;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
